mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the core pipeline, directly downstream of `ex_stage`. It consumes the `core::pipeline_bus_t` that EX produces, performs loads and stores against a request/grant/rvalid data-memory port, and aligns and extends load data. It passes the completed bus to write-back and stalls EX while a memory transaction is outstanding.

## Interface
- `ADDR_WIDTH`, default 32: data-memory address width.
- `MAX_WAIT`, default 15: number of cycles spent in WAIT without `dmem_rvalid_i` before the load is aborted.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `bus_i` in `pipeline_bus_t`: bus from EX.
  - `rd_res` carries the effective address.
  - `rs2_data` carries the store data.
  - `mem_op` selects the access.
- `valid_i` in 1: `bus_i` holds a real instruction.
- `stall_o` out 1: EX must hold `bus_i` and `valid_i`.
- `dmem_req_o` out 1: memory request.
- `dmem_we_o` out 1: 1 = store.
- `dmem_addr_o` out `ADDR_WIDTH`: word-aligned address; bits [1:0] are 0.
- `dmem_wdata_o` out `core::DATA_WIDTH`: store data, lane-replicated.
- `dmem_be_o` out `core::DATA_BYTES`: byte enables.
- `dmem_gnt_i` in 1: request accepted.
- `dmem_rvalid_i` in 1: read data valid.
- `dmem_rdata_i` in `core::DATA_WIDTH`: read data word.
- `mem_bus_o` out `pipeline_bus_t`: registered bus to WB.
- `mem_valid_o` out 1: `mem_bus_o` is new this cycle (1-cycle pulse).
- `misaligned_o` out 1: pulses together with `mem_valid_o` for a misaligned access.
- `err_o` out 1: pulses together with `mem_valid_o` for a load that timed out.

## Operation
- **Access classes.** Loads are LB/LH/LW/LBU/LHU. Stores are SB/SH/SW. Any other `mem_op` value is a pass-through.
- **Misalignment.** An access is misaligned when:
  - it is a halfword access (LH/LHU/SH) and addr[0]=1, or
  - it is a word access (LW/SW) and addr[1:0]≠0.
- **FSM states:** IDLE, REQ, WAIT.
- **IDLE, `valid_i`=1, pass-through:** `mem_bus_o` ← `bus_i` at the next edge; `mem_valid_o`=1.
- **IDLE, `valid_i`=1, misaligned access:**
  - No memory access is issued.
  - `mem_bus_o` ← `bus_i` with `rd`=0 and `rd_res`=0.
  - `mem_valid_o`=1 and `misaligned_o`=1.
- **IDLE, `valid_i`=1, aligned access:** `bus_i` is latched internally; state goes to REQ.
- **IDLE, `valid_i`=0:** `mem_bus_o` holds its value; `mem_valid_o`=0.
- **REQ:**
  - `dmem_req_o`=1. `dmem_addr_o`, `dmem_we_o`, `dmem_be_o` and `dmem_wdata_o` stay stable until `dmem_gnt_i`.
  - On `dmem_gnt_i` for a store: `mem_bus_o` ← latched bus, `mem_valid_o`=1, state goes to IDLE.
  - On `dmem_gnt_i` for a load: state goes to WAIT and the wait counter is cleared.
- **WAIT:**
  - `dmem_req_o`=0.
  - On `dmem_rvalid_i`: `mem_bus_o` ← latched bus with `rd_res` = extracted data, `mem_valid_o`=1, state goes to IDLE.
  - When the counter reaches `MAX_WAIT`: `rd`=0, `rd_res`=0, `err_o`=1, `mem_valid_o`=1, state goes to IDLE.
- **Stall:** `stall_o` = (state≠IDLE). This is combinational from state.
- **Store byte enables and data:**
  - SB: be = 1<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
- **Load extraction:**
  - Byte select = rdata >> (8·addr[1:0]).
  - LB/LH sign-extend bit 7/15. LBU/LHU zero-extend. LW uses the full word.
- **Unsolicited responses:** `dmem_rvalid_i` outside WAIT and `dmem_gnt_i` outside REQ are ignored.

## Timing
- **Reset values** (at a clock edge with `rst`=1):
  - State is IDLE.
  - `mem_bus_o` = all zeros.
  - `mem_valid_o`, `misaligned_o`, `err_o` = 0.
  - Because state is IDLE, `stall_o` = 0 and `dmem_req_o` = 0 in the following cycle.
- **Reset mid-transaction:** the transaction is abandoned and no `mem_valid_o` pulse is produced. A late `rvalid` after reset is ignored.
- **Latencies** (from the acceptance edge to `mem_valid_o`):
  - Pass-through or misaligned: 1 cycle.
  - Store: 1 + (cycles until gnt) + 1; minimum 2.
  - Load: minimum 3, with gnt in the first REQ cycle and rvalid in the first WAIT cycle.
- **Memory port rules:**
  - The earliest `rvalid` is the cycle after `gnt`.
  - `gnt` and `rvalid` in the same cycle is illegal for the memory; the `rvalid` is ignored.
- **Stall window:** `stall_o` is high from the cycle after acceptance through the completing cycle. The instruction held by EX is accepted in the first IDLE cycle after completion, which gives a one-bubble minimum between memory ops.
- **Counter width:** the wait counter is wide enough for `MAX_WAIT`. A timeout fires in the cycle the count equals `MAX_WAIT` with no `rvalid`.

## Test plan
- **Pass-through:** ADD with `rd_res`=0x1234, `valid_i`=1 → next cycle `mem_valid_o`=1, `mem_bus_o.rd_res`=0x1234, `stall_o`=0, `dmem_req_o` never asserted.
- **Store byte:** SB, addr 0x1003, rs2=0xAABBCCDD, `gnt` after 2 cycles → `dmem_addr_o`=0x1000, `be`=4'b1000, `wdata`=0xDDDDDDDD held for both cycles; `mem_valid_o` one cycle after `gnt`; `stall_o` high throughout.
- **Loads:**
  - LB, addr 0x2002, `rdata`=0x0080FF00 → `rd_res`=0xFFFFFF80.
  - LBU at the same address and data → `rd_res`=0x00000080.
  - LH, addr 0x2002 → `rd_res`=0x00000080.
  - Load latency is 3 with immediate `gnt` and `rvalid`.
- **Misaligned:** LW at 0x3001 → no `dmem_req_o`; one cycle later `misaligned_o`=`mem_valid_o`=1, `rd`=0.
- **Timeout and reset:**
  - Load granted, `rvalid` never comes → after 15 WAIT cycles `err_o`=1, `rd`=0.
  - Separately, assert `rst` in REQ → next cycle `dmem_req_o`=0, `stall_o`=0; a later `rvalid` produces no `mem_valid_o`.
- **Back-to-back:** SW followed by LW held under `stall_o` → LW is accepted in the first IDLE cycle after the SW completes; exactly two `mem_valid_o` pulses, in order.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid data port,
// aligns and extends load data, and stalls EX while a transaction is open.
package core;
  localparam int DATA_WIDTH = 32;
  localparam int DATA_BYTES = DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic [31:0]           pc;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rd_res;
    logic [DATA_WIDTH-1:0] rs2_data;
    mem_op_t               mem_op;
  } pipeline_bus_t;
endpackage

module mem_stage
  import core::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pipeline_bus_t         bus_i,
  input  logic                  valid_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [DATA_BYTES-1:0] dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output pipeline_bus_t         mem_bus_o,
  output logic                  mem_valid_o,
  output logic                  misaligned_o,
  output logic                  err_o
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state, state_nxt;
  pipeline_bus_t    lat_bus;
  logic [CNT_W-1:0] wait_cnt, cnt_inc;
  logic             in_mem, in_mis, lat_load, timeout;
  logic [DATA_WIDTH-1:0] shifted, load_data;

  function automatic logic is_load(mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_mis(mem_op_t op, logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return |a;
      default:                 return 1'b0;
    endcase
  endfunction

  assign in_mem   = is_load(bus_i.mem_op) || is_store(bus_i.mem_op);
  assign in_mis   = is_mis(bus_i.mem_op, bus_i.rd_res[1:0]);
  assign lat_load = is_load(lat_bus.mem_op);
  assign cnt_inc  = wait_cnt + CNT_W'(1);
  // The abort decision is taken in the WAIT cycle whose count reaches MAX_WAIT.
  assign timeout  = (state == WAIT) && !dmem_rvalid_i && (cnt_inc == CNT_W'(MAX_WAIT));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_i && in_mem && !in_mis) state_nxt = REQ;
      REQ:  if (dmem_gnt_i) state_nxt = lat_load ? WAIT : IDLE;
      WAIT: if (dmem_rvalid_i || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_o    = (state != IDLE);
    dmem_req_o = (state == REQ);
    dmem_we_o  = is_store(lat_bus.mem_op);
  end

  // Request fields come from the latched bus so they stay stable until gnt.
  assign dmem_addr_o = {lat_bus.rd_res[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = '0;
    dmem_wdata_o = lat_bus.rs2_data;
    case (lat_bus.mem_op)
      MEM_SB: begin
        dmem_be_o    = DATA_BYTES'(1) << lat_bus.rd_res[1:0];
        dmem_wdata_o = {DATA_BYTES{lat_bus.rs2_data[7:0]}};
      end
      MEM_SH: begin
        dmem_be_o    = lat_bus.rd_res[1] ? 4'b1100 : 4'b0011;
        dmem_wdata_o = {2{lat_bus.rs2_data[15:0]}};
      end
      MEM_SW: dmem_be_o = '1;
      default: ;
    endcase
  end

  always_comb begin
    shifted = dmem_rdata_i >> {lat_bus.rd_res[1:0], 3'b000};
    case (lat_bus.mem_op)
      MEM_LB:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      MEM_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MEM_LH:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      MEM_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_bus      <= '0;
      wait_cnt     <= '0;
      mem_bus_o    <= '0;
      mem_valid_o  <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      mem_valid_o  <= 1'b0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        IDLE: if (valid_i) begin
          if (!in_mem) begin
            mem_bus_o   <= bus_i;
            mem_valid_o <= 1'b1;
          end else if (in_mis) begin
            mem_bus_o        <= bus_i;
            mem_bus_o.rd     <= '0;
            mem_bus_o.rd_res <= '0;
            mem_valid_o      <= 1'b1;
            misaligned_o     <= 1'b1;
          end else begin
            lat_bus <= bus_i;
          end
        end
        REQ: if (dmem_gnt_i) begin
          wait_cnt <= '0;
          if (!lat_load) begin
            mem_bus_o   <= lat_bus;
            mem_valid_o <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            mem_bus_o        <= lat_bus;
            mem_bus_o.rd_res <= load_data;
            mem_valid_o      <= 1'b1;
          end else if (timeout) begin
            mem_bus_o        <= lat_bus;
            mem_bus_o.rd     <= '0;
            mem_bus_o.rd_res <= '0;
            mem_valid_o      <= 1'b1;
            err_o            <= 1'b1;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single transactions plus
// hand-written reset, reset-mid-transaction and back-to-back sequences.
module tb_mem_stage;
  import core::*;

  logic          clk = 1'b0;
  logic          rst;
  pipeline_bus_t bus_i;
  logic          valid_i;
  logic          stall_o, dmem_req_o, dmem_we_o;
  logic [31:0]   dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]    dmem_be_o;
  logic          dmem_gnt_i, dmem_rvalid_i;
  pipeline_bus_t mem_bus_o;
  logic          mem_valid_o, misaligned_o, err_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .bus_i(bus_i), .valid_i(valid_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_bus_o(mem_bus_o), .mem_valid_o(mem_valid_o),
    .misaligned_o(misaligned_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    mem_op_t     op;
    logic [4:0]  rd;
    logic [31:0] addr, rs2, rdata;
    int          gnt_dly, rv_dly;   // rv_dly < 0: rvalid never comes
    bit          spur;              // rvalid driven alongside gnt in REQ
    int          lat;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          chk_st;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    bit          e_mis, e_err;
  } vec_t;

  vec_t vt[$];

  function automatic void add(mem_op_t op, logic [4:0] rd, logic [31:0] addr, logic [31:0] rs2,
                              logic [31:0] rdata, int gd, int rv, bit spur, int lat,
                              logic [31:0] e_res, logic [4:0] e_rd, bit e_req,
                              logic [31:0] e_addr, bit chk_st, logic [3:0] e_be,
                              logic [31:0] e_wd, bit e_mis, bit e_err);
    vec_t v;
    v.op = op; v.rd = rd; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.gnt_dly = gd; v.rv_dly = rv; v.spur = spur; v.lat = lat;
    v.e_res = e_res; v.e_rd = e_rd; v.e_req = e_req; v.e_addr = e_addr;
    v.chk_st = chk_st; v.e_be = e_be; v.e_wd = e_wd; v.e_mis = e_mis; v.e_err = e_err;
    vt.push_back(v);
  endfunction

  task automatic run(input vec_t v, input int idx);
    int cyc, nreq, nwait;
    bit done;
    logic [31:0] held;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    bus_i = '0;
    bus_i.pc = 32'h100 + idx; bus_i.rd = v.rd; bus_i.rd_res = v.addr;
    bus_i.rs2_data = v.rs2; bus_i.mem_op = v.op;
    valid_i = 1'b1;
    dmem_rdata_i = v.rdata;
    @(posedge clk);
    done = 0; cyc = 0; nreq = 0; nwait = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (mem_valid_o) begin
        done = 1;
        chk({tag, " latency"}, cyc, v.lat);
        chk({tag, " rd_res"}, mem_bus_o.rd_res, v.e_res);
        chk({tag, " rd"}, mem_bus_o.rd, v.e_rd);
        chk({tag, " pc"}, mem_bus_o.pc, 32'h100 + idx);
        chk({tag, " misaligned"}, misaligned_o, v.e_mis);
        chk({tag, " err"}, err_o, v.e_err);
        chk({tag, " stall at done"}, stall_o, 0);
        chk({tag, " req issued"}, nreq > 0, v.e_req);
      end else begin
        chk({tag, " stall"}, stall_o, 1);
        if (dmem_req_o) begin
          nreq++;
          chk({tag, " addr"}, dmem_addr_o, v.e_addr);
          chk({tag, " we"}, dmem_we_o, v.chk_st);
          if (v.chk_st) begin
            chk({tag, " be"}, dmem_be_o, v.e_be);
            chk({tag, " wdata"}, dmem_wdata_o, v.e_wd);
          end
          dmem_gnt_i = (nreq > v.gnt_dly);
          dmem_rvalid_i = v.spur;
        end else begin
          nwait++;
          dmem_rvalid_i = (v.rv_dly >= 0) && (nwait > v.rv_dly);
        end
      end
    end
    if (!done) chk({tag, " completion seen"}, 0, 1);
    held = mem_bus_o.rd_res;
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk({tag, " valid pulse ends"}, mem_valid_o, 0);
    chk({tag, " bus held"}, mem_bus_o.rd_res, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, acc_cyc;
    int pcyc[2];
    logic [31:0] pres[2];

    //   op       rd  addr          rs2           rdata        gd rv sp lat res           rd req addr        st be       wdata        mis err
    add(MEM_NONE, 5, 32'h1234,     32'h0,        32'h0,        0, 0, 0, 1, 32'h1234,     5, 0, 32'h0,     0, 4'h0,    32'h0,        0, 0);
    add(MEM_SB,   0, 32'h1003,     32'hAABBCCDD, 32'h0,        1, 0, 0, 3, 32'h1003,     0, 1, 32'h1000,  1, 4'b1000, 32'hDDDDDDDD, 0, 0);
    add(MEM_SH,   0, 32'h1002,     32'h11223344, 32'h0,        0, 0, 0, 2, 32'h1002,     0, 1, 32'h1000,  1, 4'b1100, 32'h33443344, 0, 0);
    add(MEM_SW,   0, 32'h1008,     32'hCAFEF00D, 32'h0,        0, 0, 0, 2, 32'h1008,     0, 1, 32'h1008,  1, 4'b1111, 32'hCAFEF00D, 0, 0);
    add(MEM_LB,   3, 32'h2002,     32'h0,        32'h0080FF00, 0, 0, 0, 3, 32'hFFFFFF80, 3, 1, 32'h2000,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LBU,  3, 32'h2002,     32'h0,        32'h0080FF00, 0, 0, 0, 3, 32'h00000080, 3, 1, 32'h2000,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LH,   4, 32'h2002,     32'h0,        32'h0080FF00, 0, 0, 0, 3, 32'h00000080, 4, 1, 32'h2000,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LHU,  4, 32'h2000,     32'h0,        32'h0080FF00, 0, 0, 0, 3, 32'h0000FF00, 4, 1, 32'h2000,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LH,   6, 32'h2000,     32'h0,        32'h0080FF00, 2, 3, 0, 8, 32'hFFFFFF00, 6, 1, 32'h2000,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LW,   7, 32'h2004,     32'h0,        32'hDEADBEEF, 0, 0, 0, 3, 32'hDEADBEEF, 7, 1, 32'h2004,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LB,   8, 32'h2001,     32'h0,        32'h12345678, 0, 0, 0, 3, 32'h00000056, 8, 1, 32'h2000,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LW,   9, 32'h2008,     32'h0,        32'hDEADBEEF, 0, 1, 1, 4, 32'hDEADBEEF, 9, 1, 32'h2008,  0, 4'h0,    32'h0,        0, 0);
    add(MEM_LW,   7, 32'h3001,     32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        0, 0, 32'h0,     0, 4'h0,    32'h0,        1, 0);
    add(MEM_SH,   0, 32'h3003,     32'h1,        32'h0,        0, 0, 0, 1, 32'h0,        0, 0, 32'h0,     0, 4'h0,    32'h0,        1, 0);
    add(MEM_LW,  10, 32'h4000,     32'h0,        32'h0,        0,-1, 0,17, 32'h0,        0, 1, 32'h4000,  0, 4'h0,    32'h0,        0, 1);

    // Reset state
    rst = 1'b1; valid_i = 1'b0; bus_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset mem_valid", mem_valid_o, 0);
    chk("reset misaligned", misaligned_o, 0);
    chk("reset err", err_o, 0);
    chk("reset bus zero", mem_bus_o == '0, 1);
    chk("reset stall", stall_o, 0);
    chk("reset req", dmem_req_o, 0);
    rst = 1'b0;

    foreach (vt[i]) run(vt[i], i);

    // Reset while in REQ; a late rvalid must not complete anything
    @(negedge clk);
    bus_i = '0; bus_i.mem_op = MEM_LW; bus_i.rd = 5'd3; bus_i.rd_res = 32'h5000;
    valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    chk("rst-mid req before", dmem_req_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-mid req after", dmem_req_o, 0);
    chk("rst-mid stall after", stall_o, 0);
    chk("rst-mid no valid", mem_valid_o, 0);
    dmem_rvalid_i = 1'b1;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("late rvalid no valid", mem_valid_o, 0);
    chk("late rvalid no stall", stall_o, 0);
    @(negedge clk);
    chk("late rvalid no valid 2", mem_valid_o, 0);

    // Back-to-back: SW then LW presented and held under stall
    bus_i = '0; bus_i.mem_op = MEM_SW; bus_i.rd_res = 32'h6004; bus_i.rs2_data = 32'h55;
    valid_i = 1'b1;
    dmem_rdata_i = 32'h0BADF00D;
    @(posedge clk);
    pulses = 0; acc_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus_i = '0; bus_i.mem_op = MEM_LW; bus_i.rd = 5'd9; bus_i.rd_res = 32'h6008;
      end
      if (mem_valid_o) begin
        if (pulses < 2) begin
          pcyc[pulses] = c;
          pres[pulses] = mem_bus_o.rd_res;
        end
        pulses++;
      end
      if (dmem_req_o && !dmem_we_o && acc_cyc == 0) begin
        acc_cyc = c;
        valid_i = 1'b0;
      end
      dmem_gnt_i    = dmem_req_o;
      dmem_rvalid_i = stall_o && !dmem_req_o;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; valid_i = 1'b0;
    chk("b2b pulse count", pulses, 2);
    chk("b2b lw req cycle", acc_cyc, 3);
    if (pulses >= 2) begin
      chk("b2b first cycle", pcyc[0], 2);
      chk("b2b first is sw", pres[0], 32'h6004);
      chk("b2b second cycle", pcyc[1], 5);
      chk("b2b second is lw", pres[1], 32'h0BADF00D);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
